nonce_report_queue: RTL and testbench
=====================================

// Module: nonce_report_queue
// PURPOSE
//  Sits directly downstream of the sha256_top hashing core, in the clk_dcm domain.
//  Captures each golden nonce on the rising edge of got_ticket and queues it in a small FIFO.
//  Serialises each queued nonce into 4 bytes, MSB first, for the host UART transmitter.
//  Transfers bytes over a send/busy handshake and reports drops when the queue overflows.
// PARAMETERS
//  DEPTH       4   FIFO entries; must be a power of two, 2..16
//  ADDR_BITS   2   log2(DEPTH)
//  NONCE_BITS  32  golden nonce width; fixed at 32 (4 bytes per frame)
// PORTS
//  clk           in   1          hashing clock (clk_dcm)
//  rst           in   1          synchronous reset, active-high
//  got_ticket    in   1          level from hashing core; high while its nonce output is valid
//  golden_nonce  in   32         nonce; sampled in the cycle got_ticket rises
//  tx_data       out  8          byte to transmit; stable while tx_send=1
//  tx_send       out  1          request to UART; held until tx_busy is seen high
//  tx_busy       in   1          UART busy; high from acceptance until the byte is done
//  nonce_flag    out  1          1-cycle pulse on each accepted nonce (drives LED fader)
//  queue_count   out  ADDR_BITS+1  entries held, 0..DEPTH
//  overflow      out  1          sticky; set when a nonce is dropped
//  drop_count    out  8          dropped nonces; saturates at 255
// BEHAVIOUR
//  Reset (sync, rst=1 at posedge):
//   - FIFO pointers and count go to 0.
//   - tx_send=0, tx_data=0, nonce_flag=0, overflow=0, drop_count=0.
//   - FSM goes to IDLE; got_ticket edge register is cleared to 0.
//   - Reset mid-frame abandons the frame. tx_send is low from the next cycle.
//  Capture:
//   - Registered edge detector: push when got_ticket=1 and got_ticket_q=0.
//   - got_ticket high at reset release counts as an edge on the first cycle after reset.
//   - Not full: write golden_nonce and pulse nonce_flag in the next cycle.
//   - Full: drop the nonce, set overflow, increment drop_count (saturating), no nonce_flag.
//  FIFO:
//   - Circular buffer; wr_ptr and rd_ptr wrap modulo DEPTH.
//   - queue_count is updated one cycle after push/pop.
//   - Push and pop in the same cycle: both occur and count is unchanged.
//   - This holds when full, so a push coinciding with a pop is accepted, not dropped.
//  Serializer FSM:
//   - IDLE: if count>0, pop the head into shift register sh[31:0], byte_idx=0, go to LOAD.
//   - LOAD: tx_data <= sh[31:24] (MSB first); wait for tx_busy=0, then go to SEND.
//   - SEND: tx_send=1. When tx_busy=1, tx_send <= 0 and go to WAIT.
//   - WAIT: when tx_busy=0:
//       - byte_idx==3: go to IDLE;
//       - else sh <= sh<<8, byte_idx++, go to LOAD.
//   - tx_send is held indefinitely if tx_busy never rises (no timeout).
//   - Minimum cost is 3 cycles per byte plus UART time.
//   - Next frame starts no earlier than 1 cycle after the previous WAIT exits.
//   - tx_data changes only in LOAD, never while tx_send=1.
// TESTING
//  1. rst 3 cycles, then idle:
//     -> tx_send=0, queue_count=0, overflow=0, drop_count=0 throughout.
//  2. got_ticket pulse, golden_nonce=32'hDEADBEEF, UART model with 10-cycle busy:
//     -> nonce_flag 1 pulse; bytes DE,AD,BE,EF in order; queue_count back to 0.
//  3. got_ticket held high 50 cycles:
//     -> exactly one nonce queued and one 4-byte frame sent.
//  4. tx_busy forced high, 6 tickets with DEPTH=4:
//     -> queue_count=4, overflow=1, drop_count=2; releasing busy sends the 4 oldest in order.
//  5. FIFO full; new ticket coincides with an IDLE pop:
//     -> nonce accepted, count stays 4, drop_count unchanged.
//  6. rst asserted while byte 2 is in SEND:
//     -> tx_send=0 next cycle, queue empty; next ticket sends a full 4-byte frame from byte 0.

Source files
------------

// File: rtl/nonce_report_queue.sv
// Golden-nonce report queue: captures nonces on got_ticket rising edges into a small FIFO
// and serialises each one MSB-first as four bytes over a send/busy UART handshake.
module nonce_report_queue #(
   parameter int DEPTH      = 4,
   parameter int ADDR_BITS  = 2,
   parameter int NONCE_BITS = 32
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_got_ticket,
   input  logic [NONCE_BITS-1:0] i_golden_nonce,
   output logic [7:0]            o_tx_data,
   output logic                  o_tx_send,
   input  logic                  i_tx_busy,
   output logic                  o_nonce_flag,
   output logic [ADDR_BITS:0]    o_queue_count,
   output logic                  o_overflow,
   output logic [7:0]            o_drop_count
);

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SEND, S_WAIT} state_t;

   localparam logic [ADDR_BITS:0]   L_FULL    = (ADDR_BITS+1)'(DEPTH);
   localparam logic [ADDR_BITS:0]   L_CNT_ONE = (ADDR_BITS+1)'(1);
   localparam logic [ADDR_BITS-1:0] L_PTR_ONE = ADDR_BITS'(1);

   state_t                  r_state;
   state_t                  w_state_nx;
   logic [NONCE_BITS-1:0]   r_mem [DEPTH];
   logic [ADDR_BITS-1:0]    r_wr_ptr;
   logic [ADDR_BITS-1:0]    r_rd_ptr;
   logic [ADDR_BITS:0]      r_count;
   logic                    r_ticket_q;
   logic                    r_nonce_flag;
   logic                    r_overflow;
   logic [7:0]              r_drop_count;
   logic [NONCE_BITS-1:0]   r_sh;
   logic [1:0]              r_byte_idx;
   logic [7:0]              r_tx_data;
   logic                    r_tx_send;
   logic                    w_edge;
   logic                    w_full;
   logic                    w_pop;
   logic                    w_push;
   logic                    w_drop;
   logic                    w_next_byte;

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   // A pop in the same cycle frees a slot, so a coincident push into a full queue is kept.
   assign w_edge      = i_got_ticket & ~r_ticket_q;
   assign w_full      = (r_count == L_FULL);
   assign w_pop       = (r_state == S_IDLE) && (r_count != '0);
   assign w_push      = w_edge && (!w_full || w_pop);
   assign w_drop      = w_edge && w_full && !w_pop;
   assign w_next_byte = (r_state == S_WAIT) && !i_tx_busy && (r_byte_idx != 2'd3);

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_ticket_q   <= 1'b0;
         r_wr_ptr     <= '0;
         r_rd_ptr     <= '0;
         r_count      <= '0;
         r_nonce_flag <= 1'b0;
         r_overflow   <= 1'b0;
         r_drop_count <= 8'd0;
      end else begin
         r_ticket_q   <= i_got_ticket;
         r_nonce_flag <= w_push;
         if (w_push) r_wr_ptr <= r_wr_ptr + L_PTR_ONE;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + L_PTR_ONE;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + L_CNT_ONE;
            2'b01:   r_count <= r_count - L_CNT_ONE;
            default: r_count <= r_count;
         endcase
         if (w_drop) begin
            r_overflow   <= 1'b1;
            r_drop_count <= sat_inc8(r_drop_count);
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (w_push) r_mem[r_wr_ptr] <= i_golden_nonce;
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) r_state <= S_IDLE;
      else       r_state <= w_state_nx;
   end

   always_comb begin
      w_state_nx = r_state;
      case (r_state)
         S_IDLE: if (r_count != '0) w_state_nx = S_LOAD;
         S_LOAD: if (!i_tx_busy)    w_state_nx = S_SEND;
         S_SEND: if (i_tx_busy)     w_state_nx = S_WAIT;
         S_WAIT: if (!i_tx_busy)    w_state_nx = (r_byte_idx == 2'd3) ? S_IDLE : S_LOAD;
         default:                   w_state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (w_pop)            r_sh <= r_mem[r_rd_ptr];
      else if (w_next_byte) r_sh <= {r_sh[NONCE_BITS-9:0], 8'h00};
   end

   // tx_send mirrors the SEND state; tx_data only moves in LOAD, while tx_send is low.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_tx_send  <= 1'b0;
         r_tx_data  <= 8'd0;
         r_byte_idx <= 2'd0;
      end else begin
         r_tx_send <= (w_state_nx == S_SEND);
         if (r_state == S_LOAD) r_tx_data <= r_sh[NONCE_BITS-1 -: 8];
         if (w_pop)             r_byte_idx <= 2'd0;
         else if (w_next_byte)  r_byte_idx <= r_byte_idx + 2'd1;
      end
   end

   assign o_tx_data     = r_tx_data;
   assign o_tx_send     = r_tx_send;
   assign o_nonce_flag  = r_nonce_flag;
   assign o_queue_count = r_count;
   assign o_overflow    = r_overflow;
   assign o_drop_count  = r_drop_count;

endmodule

// File: tb/tb_nonce_report_queue.sv
// Self-checking bench for nonce_report_queue: UART model with a byte scoreboard,
// overflow, coincident push/pop when full, and reset in the middle of a frame.
module tb_nonce_report_queue;

   logic        clk;
   logic        rst;
   logic        got;
   logic [31:0] nonce;
   logic [7:0]  tx_data;
   logic        tx_send;
   logic        busy;
   logic        flag;
   logic [2:0]  qcnt;
   logic        ovf;
   logic [7:0]  drops;

   int          n_chk  = 0;
   int          n_fail = 0;
   logic [7:0]  exp_q[$];

   int          busy_cnt      = 0;
   int          bif           = 0;
   int          rx_bytes      = 0;
   int          frame_end_cnt = 0;
   int          flag_cnt      = 0;
   bit          force_busy    = 0;
   bit          stall         = 0;
   logic        prev_send     = 0;
   logic [7:0]  prev_data     = 0;

   nonce_report_queue #(.DEPTH(4), .ADDR_BITS(2), .NONCE_BITS(32)) dut (
      .i_clk         (clk),
      .i_rst         (rst),
      .i_got_ticket  (got),
      .i_golden_nonce(nonce),
      .o_tx_data     (tx_data),
      .o_tx_send     (tx_send),
      .i_tx_busy     (busy),
      .o_nonce_flag  (flag),
      .o_queue_count (qcnt),
      .o_overflow    (ovf),
      .o_drop_count  (drops)
   );

   initial begin
      clk = 0;
      forever #5 clk = ~clk;
   end

   initial begin
      #600000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic push_exp(input logic [31:0] n);
      exp_q.push_back(n[31:24]);
      exp_q.push_back(n[23:16]);
      exp_q.push_back(n[15:8]);
      exp_q.push_back(n[7:0]);
   endtask

   task automatic ticket(input logic [31:0] n);
      @(negedge clk);
      got   = 1'b1;
      nonce = n;
      @(negedge clk);
      got   = 1'b0;
   endtask

   task automatic wait_frames(input int target, input string tag);
      for (int k = 0; k < 3000 && frame_end_cnt < target; k++) begin
         @(negedge clk);
         #1;
      end
      check_eq(tag, 32'(frame_end_cnt >= target), 32'd1);
   endtask

   // UART model: accepts a byte when tx_send is seen, then stays busy for 10 cycles.
   initial begin
      busy = 1'b0;
      forever begin
         @(negedge clk);
         if (flag) flag_cnt++;
         if (tx_send && prev_send) check_eq("data_stable", 32'(tx_data), 32'(prev_data));
         prev_send = tx_send;
         prev_data = tx_data;
         if (force_busy) begin
            busy = 1'b1;
         end else if (busy_cnt > 0) begin
            busy_cnt--;
            if (busy_cnt == 0) begin
               busy = 1'b0;
               if (bif == 0) frame_end_cnt++;
            end
         end else begin
            busy = 1'b0;
            if (tx_send && !(stall && bif == 2)) begin
               if (exp_q.size() == 0) begin
                  check_eq("sb_underflow", 32'(exp_q.size()), 32'd1);
               end else begin
                  check_eq("tx_byte", 32'(tx_data), 32'(exp_q.pop_front()));
               end
               rx_bytes++;
               bif      = (bif + 1) % 4;
               busy     = 1'b1;
               busy_cnt = 10;
            end
         end
      end
   end

   initial begin
      int fe;
      int fl;
      int rb;
      logic [31:0] nl [7];
      nl = '{32'hA1A2A3A4, 32'hB1B2B3B4, 32'hC1C2C3C4, 32'hD1D2D3D4,
             32'hE1E2E3E4, 32'hF1F2F3F4, 32'h7788_99AA};
      rst   = 1'b1;
      got   = 1'b0;
      nonce = 32'd0;

      // Reset and idle: everything quiet.
      repeat (3) begin
         @(negedge clk);
         #1;
         check_eq("rst_state", {tx_send, qcnt, ovf, drops, tx_data, flag}, 32'd0);
      end
      rst = 1'b0;
      repeat (10) begin
         @(negedge clk);
         #1;
         check_eq("idle_state", {tx_send, qcnt, ovf, drops, flag}, 32'd0);
      end

      // Single ticket DEADBEEF.
      fe = frame_end_cnt;
      fl = flag_cnt;
      push_exp(32'hDEADBEEF);
      ticket(32'hDEADBEEF);
      #1;
      check_eq("t2_flag_hi", 32'(flag), 32'd1);
      check_eq("t2_count1", 32'(qcnt), 32'd1);
      @(negedge clk);
      #1;
      check_eq("t2_flag_lo", 32'(flag), 32'd0);
      wait_frames(fe + 1, "t2_frame_done");
      check_eq("t2_flag_pulses", 32'(flag_cnt - fl), 32'd1);
      check_eq("t2_count0", 32'(qcnt), 32'd0);
      check_eq("t2_sb_empty", 32'(exp_q.size()), 32'd0);

      // Ticket held high for 50 cycles: only the rising edge counts.
      fe = frame_end_cnt;
      fl = flag_cnt;
      rb = rx_bytes;
      push_exp(32'h12345678);
      @(negedge clk);
      got   = 1'b1;
      nonce = 32'h12345678;
      for (int i = 1; i < 50; i++) begin
         @(negedge clk);
         nonce = $urandom;
      end
      @(negedge clk);
      got = 1'b0;
      wait_frames(fe + 1, "t3_frame_done");
      repeat (40) @(negedge clk);
      #1;
      check_eq("t3_flag_pulses", 32'(flag_cnt - fl), 32'd1);
      check_eq("t3_bytes", 32'(rx_bytes - rb), 32'd4);
      check_eq("t3_sb_empty", 32'(exp_q.size()), 32'd0);

      // Busy stuck high mid-frame, 6 tickets into a 4-deep queue.
      push_exp(32'h11223344);
      rb = rx_bytes;
      ticket(32'h11223344);
      for (int k = 0; k < 200 && rx_bytes == rb; k++) begin
         @(negedge clk);
         #1;
      end
      check_eq("t4_first_byte", 32'(rx_bytes - rb), 32'd1);
      force_busy = 1'b1;
      fl = flag_cnt;
      for (int i = 0; i < 6; i++) begin
         if (i < 4) push_exp(nl[i]);
         ticket(nl[i]);
      end
      #1;
      check_eq("t4_count", 32'(qcnt), 32'd4);
      check_eq("t4_overflow", 32'(ovf), 32'd1);
      check_eq("t4_drops", 32'(drops), 32'd2);
      @(negedge clk);
      #1;
      check_eq("t4_flag_pulses", 32'(flag_cnt - fl), 32'd4);

      // Release busy; a ticket lands exactly on the IDLE pop of a full queue.
      fe = frame_end_cnt;
      force_busy = 1'b0;
      for (int k = 0; k < 400 && frame_end_cnt == fe; k++) begin
         @(negedge clk);
         #1;
      end
      check_eq("t5_prev_frame_end", 32'(frame_end_cnt - fe), 32'd1);
      @(negedge clk);
      got   = 1'b1;
      nonce = nl[6];
      push_exp(nl[6]);
      @(negedge clk);
      got = 1'b0;
      #1;
      check_eq("t5_flag", 32'(flag), 32'd1);
      check_eq("t5_count", 32'(qcnt), 32'd4);
      check_eq("t5_drops", 32'(drops), 32'd2);
      wait_frames(fe + 6, "t5_frames_done");
      check_eq("t5_count0", 32'(qcnt), 32'd0);
      check_eq("t5_sb_empty", 32'(exp_q.size()), 32'd0);

      // Reset while the third byte is held in SEND.
      stall = 1'b1;
      rb = rx_bytes;
      exp_q.push_back(8'hCA);
      exp_q.push_back(8'hFE);
      ticket(32'hCAFEF00D);
      repeat (3) @(negedge clk);
      ticket(32'h0BADC0DE);
      for (int k = 0; k < 200 && rx_bytes < rb + 2; k++) begin
         @(negedge clk);
         #1;
      end
      check_eq("t6_two_bytes", 32'(rx_bytes - rb), 32'd2);
      repeat (40) @(negedge clk);
      #1;
      check_eq("t6_send_held", 32'(tx_send), 32'd1);
      check_eq("t6_data_b2", 32'(tx_data), 32'hF0);
      check_eq("t6_count_pre", 32'(qcnt), 32'd1);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      #1;
      check_eq("t6_send_low", 32'(tx_send), 32'd0);
      check_eq("t6_count_rst", 32'(qcnt), 32'd0);
      check_eq("t6_data_rst", 32'(tx_data), 32'd0);
      check_eq("t6_status_rst", {ovf, drops}, 32'd0);
      rst   = 1'b0;
      stall = 1'b0;
      bif   = 0;
      check_eq("t6_sb_empty", 32'(exp_q.size()), 32'd0);
      fe = frame_end_cnt;
      rb = rx_bytes;
      push_exp(32'h5A5AC3C3);
      ticket(32'h5A5AC3C3);
      wait_frames(fe + 1, "t6_frame_done");
      repeat (40) @(negedge clk);
      #1;
      check_eq("t6_bytes", 32'(rx_bytes - rb), 32'd4);
      check_eq("t6_sb_final", 32'(exp_q.size()), 32'd0);
      check_eq("t6_count_final", 32'(qcnt), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
